mouse_move_encoder: RTL

MOUSE_MOVE_ENCODER -- requirements
Module: mouse_move_encoder

---
 rtl/mouse_move_encoder_if.sv | 28 ++
 rtl/mouse_move_encoder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mouse_move_encoder_if.sv
// Mouse-packet / game-status / move-strobe bundle for mouse_move_encoder.
// The encoder sits on the slave side; the packet source and game logic use master.
interface mouse_move_encoder_if;
  logic       pkt_valid;
  logic [8:0] pkt_dx;
  logic [8:0] pkt_dy;
  logic       pkt_left;
  logic [1:0] game_state;
  logic [1:0] win_status;
  logic [8:0] occupied;
  logic [9:0] cursor_x;
  logic [9:0] cursor_y;
  logic [3:0] hover_cell;
  logic       o_signal;
  logic       x_signal;
  logic [3:0] o_coodinate;
  logic [3:0] x_coodinate;

  modport master (
    output pkt_valid, pkt_dx, pkt_dy, pkt_left, game_state, win_status, occupied,
    input  cursor_x, cursor_y, hover_cell, o_signal, x_signal, o_coodinate, x_coodinate
  );

  modport slave (
    input  pkt_valid, pkt_dx, pkt_dy, pkt_left, game_state, win_status, occupied,
    output cursor_x, cursor_y, hover_cell, o_signal, x_signal, o_coodinate, x_coodinate
  );
endinterface

// File: rtl/mouse_move_encoder.sv
// Turns mouse packets into a clamped cursor, the hovered tic-tac-toe cell and o/x move strobes.
// Optional macro OCCUPIED_FILTER_EN: drop clicks on cells already marked in the occupied map.
module mouse_move_encoder #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BOARD_X0  = 200,
  parameter int BOARD_Y0  = 120,
  parameter int CELL      = 80,
  parameter int PULSE_LEN = 4
) (
  input logic                clock,
  input logic                reset,
  mouse_move_encoder_if.slave bus
);

  localparam logic [9:0]        CUR_X_RST = 10'(BOARD_X0 + (3 * CELL) / 2);
  localparam logic [9:0]        CUR_Y_RST = 10'(BOARD_Y0 + (3 * CELL) / 2);
  localparam logic signed [10:0] X_MAX    = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] Y_MAX    = 11'(SCREEN_H - 1);
  localparam logic [9:0]        BX0       = 10'(BOARD_X0);
  localparam logic [9:0]        BY0       = 10'(BOARD_Y0);
  localparam logic [9:0]        BX1       = 10'(BOARD_X0 + 3 * CELL);
  localparam logic [9:0]        BY1       = 10'(BOARD_Y0 + 3 * CELL);
  localparam logic [9:0]        C1        = 10'(CELL);
  localparam logic [9:0]        C2        = 10'(2 * CELL);
  localparam logic [3:0]        CNT_LOAD  = 4'(PULSE_LEN - 1);
  localparam logic [3:0]        NO_CELL   = 4'hF;

  typedef enum logic [2:0] {IDLE, LATCH, DRIVE, TAIL, WAIT_REL} state_t;

  state_t     state;
  logic [9:0] cursor_x_q, cursor_y_q;
  logic [3:0] hover;
  logic       prev_left;
  logic       sel_x;
  logic [3:0] cnt;
  logic       o_sig_q, x_sig_q;
  logic [3:0] o_coord_q, x_coord_q;

  logic signed [10:0] x_sum, y_sum;
  logic               click;
  logic               cell_ok;
  logic               move_ok;

  function automatic logic [9:0] clamp(input logic signed [10:0] v,
                                       input logic signed [10:0] hi);
    if (v < 11'sd0)  return 10'd0;
    else if (v > hi) return hi[9:0];
    else             return v[9:0];
  endfunction

  function automatic logic [1:0] cell_index(input logic [9:0] off);
    if (off < C1)      return 2'd0;
    else if (off < C2) return 2'd1;
    else               return 2'd2;
  endfunction

  // Screen Y grows downward while packet dy is positive-up, hence the subtraction.
  assign x_sum = $signed({1'b0, cursor_x_q}) + $signed({{2{bus.pkt_dx[8]}}, bus.pkt_dx});
  assign y_sum = $signed({1'b0, cursor_y_q}) - $signed({{2{bus.pkt_dy[8]}}, bus.pkt_dy});

  always_comb begin
    hover = NO_CELL;
    if (cursor_x_q >= BX0 && cursor_x_q < BX1 && cursor_y_q >= BY0 && cursor_y_q < BY1)
      hover = 4'(cell_index(cursor_y_q - BY0)) * 4'd3 + 4'(cell_index(cursor_x_q - BX0));
  end

  assign click = bus.pkt_valid && bus.pkt_left && !prev_left;

`ifdef OCCUPIED_FILTER_EN
  logic [8:0] occ_shifted;
  assign occ_shifted = bus.occupied >> hover;
  assign cell_ok     = !occ_shifted[0];
`else
  logic unused_occupied;
  assign unused_occupied = ^bus.occupied;
  assign cell_ok         = 1'b1;
`endif

  assign move_ok = click && (hover != NO_CELL) && (bus.win_status == 2'b00) &&
                   !bus.game_state[1] && cell_ok;

  // Cursor and button history track every packet, whatever the FSM is doing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cursor_x_q <= CUR_X_RST;
      cursor_y_q <= CUR_Y_RST;
      prev_left  <= 1'b0;
    end else if (bus.pkt_valid) begin
      cursor_x_q <= clamp(x_sum, X_MAX);
      cursor_y_q <= clamp(y_sum, Y_MAX);
      prev_left  <= bus.pkt_left;
    end
  end

  // The coordinate is loaded on entry to LATCH so it is settled a full clock before the strobe rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel_x     <= 1'b0;
      cnt       <= 4'd0;
      o_sig_q   <= 1'b0;
      x_sig_q   <= 1'b0;
      o_coord_q <= NO_CELL;
      x_coord_q <= NO_CELL;
    end else begin
      case (state)
        IDLE: begin
          if (move_ok) begin
            sel_x <= bus.game_state[0];
            if (bus.game_state[0]) x_coord_q <= hover;
            else                   o_coord_q <= hover;
            state <= LATCH;
          end
        end
        LATCH: begin
          if (sel_x) x_sig_q <= 1'b1;
          else       o_sig_q <= 1'b1;
          cnt   <= CNT_LOAD;
          state <= DRIVE;
        end
        DRIVE: begin
          if (cnt == 4'd0) begin
            o_sig_q <= 1'b0;
            x_sig_q <= 1'b0;
            state   <= TAIL;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        TAIL: state <= WAIT_REL;
        WAIT_REL: begin
          if (bus.pkt_valid && !bus.pkt_left) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cursor_x    = cursor_x_q;
  assign bus.cursor_y    = cursor_y_q;
  assign bus.hover_cell  = hover;
  assign bus.o_signal    = o_sig_q;
  assign bus.x_signal    = x_sig_q;
  assign bus.o_coodinate = o_coord_q;
  assign bus.x_coodinate = x_coord_q;

endmodule
